isqrt_rr_arbiter: RTL and testbench
===================================

Name: isqrt_rr_arbiter

Overview:
- Shares one pipelined isqrt instance between N_REQ requesters, for example several formula FSMs that each need square roots.
- Round-robin arbitration issues at most one request per cycle to isqrt.
- A tag FIFO records the owner of every in-flight request, so each result is routed back to the requester that issued it.
- Sits between the formula controllers and the isqrt datapath; isqrt returns results in issue order.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TAG_DEPTH, 16, maximum in-flight requests; must be at least the isqrt latency; power of 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_x_vld  in  N_REQ  per-requester request valid.
- req_x  in  N_REQ*32  per-requester argument; slice i is [32*i +: 32].
- req_x_rdy  out  N_REQ  grant; a request is accepted in a cycle where vld and rdy are both 1.
- req_y_vld  out  N_REQ  per-requester result valid, one-cycle pulse.
- req_y  out  16  result data, shared by all requesters; qualified by req_y_vld.
- isqrt_x_vld  out  1  issue to isqrt.
- isqrt_x  out  32  argument to isqrt.
- isqrt_y_vld  in  1  isqrt result valid.
- isqrt_y  in  16  isqrt result.
- err  out  1  sticky: a result arrived while the tag FIFO was empty.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: req_y_vld=0, req_y=0, err=0.
  - State: tag FIFO empty (count=0), round-robin pointer=0.
  - Takes effect immediately; no cycle is required.
- Arbitration (combinational):
  - can_issue = (count < TAG_DEPTH).
  - Winner = first i with req_x_vld[i]=1, searching i = ptr, ptr+1, ..., wrapping modulo N_REQ.
  - req_x_rdy is one-hot on the winner when can_issue=1 and any vld is set; otherwise all zero.
  - isqrt_x_vld = |(req_x_vld & req_x_rdy).
  - isqrt_x = req_x of the winner, or 0 when nothing is issued.
  - A requester holds vld and x stable until granted.
- Pointer: on an issue, ptr <= (winner+1) mod N_REQ; it is unchanged on idle cycles.
- Tag FIFO:
  - Push the winner index on issue; pop on isqrt_y_vld.
  - Push and pop in the same cycle leave count unchanged.
  - Full (count=TAG_DEPTH): no grant, even if a pop occurs in that cycle. Conservative by design; no same-cycle pass-through.
  - Read and write pointers wrap modulo TAG_DEPTH.
- Result routing (registered, latency 1 cycle from isqrt_y_vld):
  - req_y_vld[tag_head] <= 1, all other bits 0.
  - req_y <= isqrt_y.
  - req_y_vld returns to 0 in cycles with no isqrt_y_vld.
- Empty-FIFO result: if isqrt_y_vld arrives with count=0, the result is dropped; no req_y_vld is asserted and err <= 1. err clears only on reset.
- Reset mid-operation:
  - In-flight tags are lost.
  - Late isqrt results after reset hit the empty-FIFO rule above. Integrators must flush isqrt together with this block.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,N_REQ-1 and no requester waits more than N_REQ-1 issues.
- No internal state machine beyond the pointer and FIFO. Throughput is 1 request per cycle.

Optional Feature:
- Macro: ISQRT_RR_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_cnt (N_REQ*16), slice i = number of accepted requests from requester i.
  - Adds output max_inflight (16), high-water mark of count.
  - Counters saturate at 16'hFFFF; reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single requester: N_REQ=2, isqrt latency 4, req 0 sends x=16 -> granted the same cycle; req_y_vld=2'b01 with req_y=4 exactly 5 cycles after issue.
- Contention: both requesters hold vld, req 0 x=9 and req 1 x=25 -> grants alternate 0,1,0,1; each receives 3 and 5 respectively, with req_y_vld one-hot on the correct owner every time.
- Full FIFO: TAG_DEPTH=4, isqrt stalled (no y_vld), continuous requests -> exactly 4 grants, then req_x_rdy=0. After one y_vld, one grant is allowed on the next cycle.
- Spurious result: isqrt_y_vld pulse with FIFO empty -> no req_y_vld; err=1 and it stays 1 until rst_n=0.
- Async reset mid-flight: 3 outstanding requests, rst_n driven low between clock edges -> req_y_vld, err and count are 0 immediately. The late results set err and are not delivered.
- Stats (with ISQRT_RR_ARBITER_STATS_EN): 10 grants to req 0 and 7 to req 1 -> grant_cnt = {16'd7, 16'd10}; max_inflight equals the observed peak.

Source files
------------

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin share of one in-order isqrt pipe among N_REQ requesters; a tag FIFO routes each result home.
// Latency: grant/issue combinational, result 1 cycle after isqrt_y_vld; no grant while TAG_DEPTH tags are in flight.
// Optional macro ISQRT_RR_ARBITER_STATS_EN adds per-requester grant counters and an in-flight high-water mark.
module isqrt_rr_arbiter #(
  parameter int N_REQ     = 2,
  parameter int TAG_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_x_vld,
  input  logic [N_REQ*32-1:0]   req_x,
  output logic [N_REQ-1:0]      req_x_rdy,
  output logic [N_REQ-1:0]      req_y_vld,
  output logic [15:0]           req_y,
  output logic                  isqrt_x_vld,
  output logic [31:0]           isqrt_x,
  input  logic                  isqrt_y_vld,
  input  logic [15:0]           isqrt_y,
  output logic                  err
`ifdef ISQRT_RR_ARBITER_STATS_EN
  ,
  output logic [N_REQ*16-1:0]   grant_cnt,
  output logic [15:0]           max_inflight
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    nxt_ptr;
  logic             found;
  logic             can_issue;
  logic             issue;
  logic             pop;
  logic             spurious;
  logic [CW-1:0]    count;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [IW-1:0]    tag_mem [TAG_DEPTH];
  logic [IW-1:0]    tag_head;
  logic [N_REQ-1:0] y_onehot;

  // Search starts at ptr and wraps, so the last winner has lowest priority next time.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (!found && req_x_vld[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Full blocks grants even when a pop lands in the same cycle.
  assign can_issue = (count < CW'(TAG_DEPTH));
  assign issue     = found & can_issue;
  assign pop       = isqrt_y_vld && (count != '0);
  assign spurious  = isqrt_y_vld && (count == '0);
  assign tag_head  = tag_mem[rd_ptr];
  assign nxt_ptr   = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    req_x_rdy = '0;
    isqrt_x   = '0;
    y_onehot  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (issue && winner == IW'(k)) begin
        req_x_rdy[k] = 1'b1;
        isqrt_x      = req_x[32*k +: 32];
      end
      if (pop && tag_head == IW'(k)) begin
        y_onehot[k] = 1'b1;
      end
    end
  end

  assign isqrt_x_vld = |(req_x_vld & req_x_rdy);

  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[wr_ptr] <= winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      req_y_vld <= '0;
      req_y     <= '0;
      err       <= 1'b0;
    end else begin
      if (issue) begin
        ptr    <= nxt_ptr;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        req_y  <= isqrt_y;
      end
      case ({issue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      req_y_vld <= y_onehot;
      if (spurious) begin
        err <= 1'b1;
      end
    end
  end

`ifdef ISQRT_RR_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt    <= '0;
      max_inflight <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (issue && winner == IW'(k) && grant_cnt[16*k +: 16] != 16'hFFFF) begin
          grant_cnt[16*k +: 16] <= grant_cnt[16*k +: 16] + 16'd1;
        end
      end
      if (16'(count) > max_inflight) begin
        max_inflight <= 16'(count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Bench for isqrt_rr_arbiter: 4-cycle isqrt model with stall/inject controls, scoreboard of owner/result pairs.
module tb_isqrt_rr_arbiter;
  localparam int N   = 2;
  localparam int TD  = 4;
  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N-1:0]      req_x_vld = '0;
  logic [N*32-1:0]   req_x = '0;
  logic [N-1:0]      req_x_rdy;
  logic [N-1:0]      req_y_vld;
  logic [15:0]       req_y;
  logic              isqrt_x_vld;
  logic [31:0]       isqrt_x;
  logic              isqrt_y_vld = 1'b0;
  logic [15:0]       isqrt_y = '0;
  logic              err;
`ifdef ISQRT_RR_ARBITER_STATS_EN
  logic [N*16-1:0]   grant_cnt;
  logic [15:0]       max_inflight;
`endif

  int checks = 0;
  int errors = 0;
  logic stall = 1'b0;
  logic inject = 1'b0;
  int cyc = 0;
  int pt[$];
  logic [31:0] px[$];
  logic [N-1:0] exp_own[$];
  logic [15:0]  exp_val[$];

  always #5 clk = ~clk;

  isqrt_rr_arbiter #(.N_REQ(N), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_x_vld(req_x_vld), .req_x(req_x), .req_x_rdy(req_x_rdy),
    .req_y_vld(req_y_vld), .req_y(req_y),
    .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
    .err(err)
`ifdef ISQRT_RR_ARBITER_STATS_EN
    , .grant_cnt(grant_cnt), .max_inflight(max_inflight)
`endif
  );

  function automatic logic [15:0] isqrt_f(input logic [31:0] x);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 70000; i++) begin
      if ((64'(r) + 1) * (64'(r) + 1) <= 64'(x)) r = r + 1;
    end
    return r[15:0];
  endfunction

  // In-order isqrt environment model: fixed latency, can be stalled or forced to emit a stray result.
  always @(negedge clk) begin
    if (isqrt_x_vld) begin
      pt.push_back(cyc);
      px.push_back(isqrt_x);
    end
    if (inject) begin
      isqrt_y_vld = 1'b1;
      isqrt_y     = 16'hBEEF;
    end else if (!stall && pt.size() > 0 && cyc >= pt[0] + LAT) begin
      isqrt_y_vld = 1'b1;
      isqrt_y     = isqrt_f(px[0]);
      void'(pt.pop_front());
      void'(px.pop_front());
    end else begin
      isqrt_y_vld = 1'b0;
      isqrt_y     = '0;
    end
    cyc = cyc + 1;
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (req_y_vld !== '0) begin errors++; $display("FAIL reset_req_y_vld got %b want 00", req_y_vld); end
    checks++;
    if (req_y !== 16'd0) begin errors++; $display("FAIL reset_req_y got %0d want 0", req_y); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++;
    if (req_x_rdy !== '0 || isqrt_x_vld !== 1'b0 || isqrt_x !== 32'd0) begin
      errors++; $display("FAIL reset_idle got rdy=%b vld=%b x=%0d want 00/0/0", req_x_rdy, isqrt_x_vld, isqrt_x);
    end
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_single();
    int got_k;
    got_k = -1;
    @(posedge clk); #1;
    req_x[31:0] = 32'd16;
    req_x_vld   = 2'b01;
    @(negedge clk);
    checks++;
    if (req_x_rdy !== 2'b01 || isqrt_x_vld !== 1'b1 || isqrt_x !== 32'd16) begin
      errors++; $display("FAIL single_issue got rdy=%b vld=%b x=%0d want 01/1/16", req_x_rdy, isqrt_x_vld, isqrt_x);
    end
    exp_own.push_back(2'b01); exp_val.push_back(16'd4);
    @(posedge clk); #1;
    req_x_vld = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (req_y_vld !== '0) begin
        checks++;
        if (got_k < 0) got_k = k;
        if (exp_own.size() == 0) begin
          errors++; $display("FAIL single_extra got req_y_vld=%b want 00", req_y_vld);
        end else begin
          if (req_y_vld !== exp_own[0] || req_y !== exp_val[0]) begin
            errors++; $display("FAIL single_result got %b/%0d want %b/%0d", req_y_vld, req_y, exp_own[0], exp_val[0]);
          end
          void'(exp_own.pop_front()); void'(exp_val.pop_front());
        end
      end
    end
    checks++;
    if (got_k !== 5) begin errors++; $display("FAIL single_latency got %0d want 5", got_k); end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_rdy;
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      req_x     = {32'd25, 32'd9};
      req_x_vld = 2'b11;
      @(negedge clk);
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (req_x_rdy !== exp_rdy) begin errors++; $display("FAIL contention_grant k=%0d got %b want %b", k, req_x_rdy, exp_rdy); end
      exp_own.push_back(exp_rdy);
      exp_val.push_back(exp_rdy == 2'b01 ? 16'd3 : 16'd5);
    end
    @(posedge clk); #1;
    req_x_vld = '0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (req_y_vld !== '0) begin
        checks++;
        if (exp_own.size() == 0) begin
          errors++; $display("FAIL contention_extra got req_y_vld=%b want 00", req_y_vld);
        end else begin
          if (req_y_vld !== exp_own[0] || req_y !== exp_val[0]) begin
            errors++; $display("FAIL contention_result got %b/%0d want %b/%0d", req_y_vld, req_y, exp_own[0], exp_val[0]);
          end
          void'(exp_own.pop_front()); void'(exp_val.pop_front());
        end
      end
    end
    checks++;
    if (exp_own.size() != 0) begin errors++; $display("FAIL contention_missing got %0d pending want 0", exp_own.size()); end
  endtask

  task automatic test_full();
    logic [N-1:0] exp_rdy;
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      req_x[31:0] = 32'd4;
      req_x_vld   = 2'b01;
      stall       = (k == 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      exp_rdy = (k < TD || k == 7) ? 2'b01 : 2'b00;
      checks++;
      if (req_x_rdy !== exp_rdy) begin errors++; $display("FAIL full_grant k=%0d got %b want %b", k, req_x_rdy, exp_rdy); end
      if (exp_rdy != '0) begin exp_own.push_back(2'b01); exp_val.push_back(16'd2); end
      if (req_y_vld !== '0) begin
        checks++;
        if (exp_own.size() == 0) begin
          errors++; $display("FAIL full_extra got req_y_vld=%b want 00", req_y_vld);
        end else begin
          if (req_y_vld !== exp_own[0] || req_y !== exp_val[0]) begin
            errors++; $display("FAIL full_result got %b/%0d want %b/%0d", req_y_vld, req_y, exp_own[0], exp_val[0]);
          end
          void'(exp_own.pop_front()); void'(exp_val.pop_front());
        end
      end
    end
    @(posedge clk); #1;
    req_x_vld = '0;
    stall     = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_y_vld !== '0) begin
        checks++;
        if (exp_own.size() == 0) begin
          errors++; $display("FAIL full_extra got req_y_vld=%b want 00", req_y_vld);
        end else begin
          if (req_y_vld !== exp_own[0] || req_y !== exp_val[0]) begin
            errors++; $display("FAIL full_result got %b/%0d want %b/%0d", req_y_vld, req_y, exp_own[0], exp_val[0]);
          end
          void'(exp_own.pop_front()); void'(exp_val.pop_front());
        end
      end
    end
    checks++;
    if (exp_own.size() != 0) begin errors++; $display("FAIL full_missing got %0d pending want 0", exp_own.size()); end
  endtask

  task automatic test_spurious();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      inject = (k == 0);
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL spurious_pre_err got %b want 0", err); end
      end else begin
        checks++;
        if (req_y_vld !== '0 || err !== 1'b1) begin
          errors++; $display("FAIL spurious_k%0d got vld=%b err=%b want 00/1", k, req_y_vld, err);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL spurious_clear got %b want 0", err); end
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      req_x[31:0] = 32'd16;
      req_x_vld   = (k < 3) ? 2'b01 : 2'b00;
      if (k == 5) begin
        #1;
        checks++;
        if (req_y_vld !== 2'b01 || req_y !== 16'd4) begin
          errors++; $display("FAIL async_first got %b/%0d want 01/4", req_y_vld, req_y);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (req_y_vld !== '0 || err !== 1'b0) begin
          errors++; $display("FAIL async_immediate got vld=%b err=%b want 00/0", req_y_vld, err);
        end
      end
      if (k == 6) rst_n = 1'b1;
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if (req_x_rdy !== 2'b01) begin errors++; $display("FAIL async_grant k=%0d got %b want 01", k, req_x_rdy); end
      end
      if (k >= 6) begin
        checks++;
        if (req_y_vld !== '0) begin errors++; $display("FAIL async_late_delivered k=%0d got %b want 00", k, req_y_vld); end
      end
      if (k >= 7) begin
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL async_late_err k=%0d got %b want 1", k, err); end
      end
    end
    // Pointer must be back at 0: requester 0 wins although it won last before reset.
    @(posedge clk); #1;
    req_x     = {32'd25, 32'd9};
    req_x_vld = 2'b11;
    @(negedge clk);
    checks++;
    if (req_x_rdy !== 2'b01) begin errors++; $display("FAIL async_ptr got %b want 01", req_x_rdy); end
    exp_own.push_back(2'b01); exp_val.push_back(16'd3);
    @(posedge clk); #1;
    req_x_vld = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_y_vld !== '0) begin
        checks++;
        if (exp_own.size() == 0) begin
          errors++; $display("FAIL async_extra got req_y_vld=%b want 00", req_y_vld);
        end else begin
          if (req_y_vld !== exp_own[0] || req_y !== exp_val[0]) begin
            errors++; $display("FAIL async_result got %b/%0d want %b/%0d", req_y_vld, req_y, exp_own[0], exp_val[0]);
          end
          void'(exp_own.pop_front()); void'(exp_val.pop_front());
        end
      end
    end
    checks++;
    if (exp_own.size() != 0) begin errors++; $display("FAIL async_missing got %0d pending want 0", exp_own.size()); end
  endtask

`ifdef ISQRT_RR_ARBITER_STATS_EN
  task automatic test_stats();
    int n0;
    int n1;
    n0 = 10;
    n1 = 7;
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 200 && (n0 > 0 || n1 > 0); k++) begin
      @(posedge clk); #1;
      req_x     = {32'd25, 32'd9};
      req_x_vld = {n1 > 0, n0 > 0};
      @(negedge clk);
      if (req_x_rdy[0]) n0--;
      if (req_x_rdy[1]) n1--;
    end
    @(posedge clk); #1;
    req_x_vld = '0;
    repeat (20) @(negedge clk);
    checks++;
    if (n0 != 0 || n1 != 0) begin errors++; $display("FAIL stats_timeout got %0d/%0d left want 0/0", n0, n1); end
    checks++;
    if (grant_cnt !== {16'd7, 16'd10}) begin errors++; $display("FAIL stats_grant_cnt got %h want 0007000a", grant_cnt); end
    checks++;
    if (max_inflight !== 16'd4) begin errors++; $display("FAIL stats_max_inflight got %0d want 4", max_inflight); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_spurious();
    test_async_reset();
`ifdef ISQRT_RR_ARBITER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
